// File: rtl/decode_stage_pkg.sv
// Shared pipeline types: RV32I opcodes and the decoded-instruction bundle
// passed from decode to the execute and write stages.
package decode_stage_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  // Names that collide with SV keywords carry a trailing underscore
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
    logic addi;
    logic slti;
    logic sltiu;
    logic xori;
    logic ori;
    logic andi;
    logic slli;
    logic srli;
    logic srai;
    logic add;
    logic sub;
    logic sll;
    logic slt;
    logic sltu;
    logic xor_;
    logic srl;
    logic sra;
    logic or_;
    logic and_;
  } rv_ops_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    rv_ops_t     ops;
    logic        is_conditional_jump;
    logic        is_load;
    logic        is_store;
    logic        writes_rd;
    logic        is_illegal;
  } instructions;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Combinational RV32I decoder: raw word and pc to the decoded bundle.
// Illegal words keep only pc/rs1/rs2 plus the is_illegal flag.
module decode_comb
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_raw_i,
  input  logic [31:0] pc_i,
  output instructions dec_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        f7b;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm;
  rv_ops_t     ops;
  logic        legal;

  assign opc = instr_raw_i[6:0];
  assign f3  = instr_raw_i[14:12];
  assign f7b = instr_raw_i[30];

  assign imm_i = sext12(instr_raw_i[31:20]);
  assign imm_s = sext12({instr_raw_i[31:25], instr_raw_i[11:7]});
  assign imm_b = {{20{instr_raw_i[31]}}, instr_raw_i[7],
                  instr_raw_i[30:25], instr_raw_i[11:8], 1'b0};
  assign imm_u = {instr_raw_i[31:12], 12'b0};
  assign imm_j = {{12{instr_raw_i[31]}}, instr_raw_i[19:12],
                  instr_raw_i[20], instr_raw_i[30:21], 1'b0};

  always_comb begin
    ops = '0;
    imm = '0;
    unique case (opc)
      LUI: begin
        ops.lui = 1'b1;
        imm     = imm_u;
      end
      AUIPC: begin
        ops.auipc = 1'b1;
        imm       = imm_u;
      end
      JAL: begin
        ops.jal = 1'b1;
        imm     = imm_j;
      end
      JALR: begin
        ops.jalr = (f3 == 3'b000);
        imm      = imm_i;
      end
      BRANCH: begin
        ops.beq  = (f3 == 3'b000);
        ops.bne  = (f3 == 3'b001);
        ops.blt  = (f3 == 3'b100);
        ops.bge  = (f3 == 3'b101);
        ops.bltu = (f3 == 3'b110);
        ops.bgeu = (f3 == 3'b111);
        imm      = imm_b;
      end
      LOAD: begin
        ops.lb  = (f3 == 3'b000);
        ops.lh  = (f3 == 3'b001);
        ops.lw  = (f3 == 3'b010);
        ops.lbu = (f3 == 3'b100);
        ops.lhu = (f3 == 3'b101);
        imm     = imm_i;
      end
      STORE: begin
        ops.sb = (f3 == 3'b000);
        ops.sh = (f3 == 3'b001);
        ops.sw = (f3 == 3'b010);
        imm    = imm_s;
      end
      OP_IMM: begin
        ops.addi  = (f3 == 3'b000);
        ops.slti  = (f3 == 3'b010);
        ops.sltiu = (f3 == 3'b011);
        ops.xori  = (f3 == 3'b100);
        ops.ori   = (f3 == 3'b110);
        ops.andi  = (f3 == 3'b111);
        ops.slli  = (f3 == 3'b001) && !f7b;
        ops.srli  = (f3 == 3'b101) && !f7b;
        ops.srai  = (f3 == 3'b101) && f7b;
        // shifts carry an unsigned shamt, not a signed immediate
        if (f3 == 3'b001 || f3 == 3'b101)
          imm = {27'b0, instr_raw_i[24:20]};
        else
          imm = imm_i;
      end
      OP: begin
        ops.add  = (f3 == 3'b000) && !f7b;
        ops.sub  = (f3 == 3'b000) && f7b;
        ops.sll  = (f3 == 3'b001) && !f7b;
        ops.slt  = (f3 == 3'b010) && !f7b;
        ops.sltu = (f3 == 3'b011) && !f7b;
        ops.xor_ = (f3 == 3'b100) && !f7b;
        ops.srl  = (f3 == 3'b101) && !f7b;
        ops.sra  = (f3 == 3'b101) && f7b;
        ops.or_  = (f3 == 3'b110) && !f7b;
        ops.and_ = (f3 == 3'b111) && !f7b;
      end
      default: ;
    endcase
  end

  assign legal = |{ops};

  always_comb begin
    dec_o     = '0;
    dec_o.pc  = pc_i;
    dec_o.rs1 = instr_raw_i[19:15];
    dec_o.rs2 = instr_raw_i[24:20];
    if (legal) begin
      dec_o.ops                 = ops;
      dec_o.imm                 = imm;
      dec_o.is_conditional_jump = (opc == BRANCH);
      dec_o.is_load             = (opc == LOAD);
      dec_o.is_store            = (opc == STORE);
      dec_o.writes_rd           = (opc != BRANCH) && (opc != STORE);
      dec_o.rd = dec_o.writes_rd ? instr_raw_i[11:7] : 5'd0;
    end else begin
      dec_o.is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers the decoded bundle and exposes
// zero-latency register-file read addresses and a may-jump hint.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic [31:0] pc,
  input  logic [31:0] instr_raw,
  output logic        completed,
  output instructions instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        may_jump
);

  instructions dec;
  instructions instr_q;
  instructions instr_d;
  logic        completed_q;
  logic        completed_d;
  logic [6:0]  opc;

  decode_comb u_comb (
    .instr_raw_i (instr_raw),
    .pc_i        (pc),
    .dec_o       (dec)
  );

  assign opc      = instr_raw[6:0];
  assign rs1      = instr_raw[19:15];
  assign rs2      = instr_raw[24:20];
  assign may_jump = (opc == JAL) || (opc == JALR) || (opc == BRANCH);

  always_comb begin
    instr_d     = instr_q;
    completed_d = 1'b0;
    if (enabled) begin
      instr_d     = dec;
      completed_d = 1'b1;
    end
  end

  // reset doubles as a pipeline flush, so it is sampled on the clock
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instr_q     <= '0;
      completed_q <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      completed_q <= completed_d;
    end
  end

  assign instr     = instr_q;
  assign completed = completed_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage.
// Each task drives one scenario and checks against hand-computed values.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enabled;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic        completed;
  instructions instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        may_jump;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk       (clk),
    .rstn      (rstn),
    .enabled   (enabled),
    .pc        (pc),
    .instr_raw (instr_raw),
    .completed (completed),
    .instr     (instr),
    .rs1       (rs1),
    .rs2       (rs2),
    .may_jump  (may_jump)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled = 1'b1;
    pc = 32'h10; instr_raw = 32'h00500093;
    tick();
    nvec++; if (completed !== 1'b0) begin nerr++;
      $display("FAIL rst_completed got %b want 0", completed); end
    nvec++; if (instr !== '0) begin nerr++;
      $display("FAIL rst_instr got %h want 0", instr); end
    rstn = 1'b1;
  endtask

  task automatic test_addi();
    enabled = 1'b1; pc = 32'h10; instr_raw = 32'h00500093;
    tick();
    nvec++; if (completed !== 1'b1) begin nerr++;
      $display("FAIL addi_completed got %b want 1", completed); end
    nvec++; if (instr.ops.addi !== 1'b1) begin nerr++;
      $display("FAIL addi_flag got %b want 1", instr.ops.addi); end
    nvec++; if (instr.rd !== 5'd1) begin nerr++;
      $display("FAIL addi_rd got %0d want 1", instr.rd); end
    nvec++; if (instr.rs1 !== 5'd0) begin nerr++;
      $display("FAIL addi_rs1 got %0d want 0", instr.rs1); end
    nvec++; if (instr.imm !== 32'd5) begin nerr++;
      $display("FAIL addi_imm got %h want 5", instr.imm); end
    nvec++; if (instr.pc !== 32'h10) begin nerr++;
      $display("FAIL addi_pc got %h want 10", instr.pc); end
    nvec++; if (instr.writes_rd !== 1'b1) begin nerr++;
      $display("FAIL addi_wrd got %b want 1", instr.writes_rd); end
    nvec++; if (instr.is_illegal !== 1'b0) begin nerr++;
      $display("FAIL addi_ill got %b want 0", instr.is_illegal); end
  endtask

  task automatic test_add();
    enabled = 1'b1; pc = 32'h14; instr_raw = 32'h002081B3;
    #1;
    nvec++; if (rs1 !== 5'd1 || rs2 !== 5'd2) begin nerr++;
      $display("FAIL add_comb_rs got %0d/%0d want 1/2", rs1, rs2); end
    nvec++; if (may_jump !== 1'b0) begin nerr++;
      $display("FAIL add_mayjump got %b want 0", may_jump); end
    tick();
    nvec++; if (instr.ops.add !== 1'b1 || instr.ops.sub !== 1'b0) begin
      nerr++; $display("FAIL add_flag got add=%b sub=%b want 1/0",
        instr.ops.add, instr.ops.sub); end
    nvec++; if (instr.rd !== 5'd3) begin nerr++;
      $display("FAIL add_rd got %0d want 3", instr.rd); end
    nvec++; if (instr.imm !== 32'd0) begin nerr++;
      $display("FAIL add_imm got %h want 0", instr.imm); end
  endtask

  task automatic test_beq();
    enabled = 1'b1; pc = 32'h18; instr_raw = 32'h00208463;
    #1;
    nvec++; if (may_jump !== 1'b1) begin nerr++;
      $display("FAIL beq_mayjump got %b want 1", may_jump); end
    tick();
    nvec++; if (instr.ops.beq !== 1'b1) begin nerr++;
      $display("FAIL beq_flag got %b want 1", instr.ops.beq); end
    nvec++; if (instr.is_conditional_jump !== 1'b1) begin nerr++;
      $display("FAIL beq_cond got %b want 1", instr.is_conditional_jump); end
    nvec++; if (instr.imm !== 32'd8) begin nerr++;
      $display("FAIL beq_imm got %h want 8", instr.imm); end
    nvec++; if (instr.rd !== 5'd0 || instr.writes_rd !== 1'b0) begin
      nerr++; $display("FAIL beq_rd got %0d/%b want 0/0",
        instr.rd, instr.writes_rd); end
  endtask

  task automatic test_jal_sw_lui();
    enabled = 1'b1; pc = 32'h1C; instr_raw = 32'h010000EF;
    #1;
    nvec++; if (may_jump !== 1'b1) begin nerr++;
      $display("FAIL jal_mayjump got %b want 1", may_jump); end
    tick();
    nvec++; if (instr.ops.jal !== 1'b1 || instr.rd !== 5'd1
        || instr.imm !== 32'd16) begin nerr++;
      $display("FAIL jal got jal=%b rd=%0d imm=%h want 1/1/10",
        instr.ops.jal, instr.rd, instr.imm); end
    instr_raw = 32'h0020A223;
    tick();
    nvec++; if (instr.ops.sw !== 1'b1 || instr.imm !== 32'd4
        || instr.rd !== 5'd0 || instr.is_store !== 1'b1) begin nerr++;
      $display("FAIL sw got sw=%b imm=%h rd=%0d st=%b want 1/4/0/1",
        instr.ops.sw, instr.imm, instr.rd, instr.is_store); end
    instr_raw = 32'h123452B7;
    tick();
    nvec++; if (instr.ops.lui !== 1'b1 || instr.rd !== 5'd5
        || instr.imm !== 32'h12345000) begin nerr++;
      $display("FAIL lui got lui=%b rd=%0d imm=%h want 1/5/12345000",
        instr.ops.lui, instr.rd, instr.imm); end
  endtask

  task automatic test_imm_edges();
    enabled = 1'b1; pc = 32'h20; instr_raw = 32'hFFF00093;
    tick();
    nvec++; if (instr.ops.addi !== 1'b1 || instr.imm !== 32'hFFFFFFFF)
      begin nerr++; $display("FAIL addi_neg got addi=%b imm=%h want 1/ffffffff",
        instr.ops.addi, instr.imm); end
    instr_raw = 32'h4030D093;
    tick();
    nvec++; if (instr.ops.srai !== 1'b1 || instr.ops.srli !== 1'b0
        || instr.imm !== 32'd3) begin nerr++;
      $display("FAIL srai got srai=%b srli=%b imm=%h want 1/0/3",
        instr.ops.srai, instr.ops.srli, instr.imm); end
    instr_raw = 32'h402081B3;
    tick();
    nvec++; if (instr.ops.sub !== 1'b1 || instr.ops.add !== 1'b0
        || instr.rd !== 5'd3) begin nerr++;
      $display("FAIL sub got sub=%b add=%b rd=%0d want 1/0/3",
        instr.ops.sub, instr.ops.add, instr.rd); end
  endtask

  task automatic test_illegal();
    enabled = 1'b1; pc = 32'h24; instr_raw = 32'hFFFFFFFF;
    tick();
    nvec++; if (instr.is_illegal !== 1'b1 || instr.rd !== 5'd0) begin
      nerr++; $display("FAIL ill_ffff got ill=%b rd=%0d want 1/0",
        instr.is_illegal, instr.rd); end
    nvec++; if (instr.ops !== '0 || instr.writes_rd !== 1'b0) begin
      nerr++; $display("FAIL ill_flags got ops=%h wrd=%b want 0/0",
        instr.ops, instr.writes_rd); end
    instr_raw = 32'h0020A463;
    tick();
    nvec++; if (instr.is_illegal !== 1'b1 || instr.ops.beq !== 1'b0
        || instr.is_conditional_jump !== 1'b0) begin nerr++;
      $display("FAIL ill_branch got ill=%b beq=%b cond=%b want 1/0/0",
        instr.is_illegal, instr.ops.beq, instr.is_conditional_jump); end
  endtask

  task automatic test_hold_flush();
    enabled = 1'b1; pc = 32'h10; instr_raw = 32'h00500093;
    tick();
    enabled = 1'b0; pc = 32'h40; instr_raw = 32'h002081B3;
    #1;
    nvec++; if (rs1 !== 5'd1 || rs2 !== 5'd2) begin nerr++;
      $display("FAIL hold_comb_rs got %0d/%0d want 1/2", rs1, rs2); end
    tick();
    nvec++; if (completed !== 1'b0) begin nerr++;
      $display("FAIL hold_completed got %b want 0", completed); end
    nvec++; if (instr.ops.addi !== 1'b1 || instr.ops.add !== 1'b0
        || instr.imm !== 32'd5 || instr.pc !== 32'h10) begin nerr++;
      $display("FAIL hold_instr got addi=%b add=%b imm=%h pc=%h want 1/0/5/10",
        instr.ops.addi, instr.ops.add, instr.imm, instr.pc); end
    rstn = 1'b0; enabled = 1'b1;
    tick();
    nvec++; if (completed !== 1'b0 || instr !== '0) begin nerr++;
      $display("FAIL flush got completed=%b instr=%h want 0/0",
        completed, instr); end
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    enabled = 1'b1; pc = 32'h100; instr_raw = 32'h00500093;
    tick();
    nvec++; if (completed !== 1'b1 || instr.ops.addi !== 1'b1) begin
      nerr++; $display("FAIL b2b_first got c=%b addi=%b want 1/1",
        completed, instr.ops.addi); end
    pc = 32'h104; instr_raw = 32'h00208463;
    tick();
    nvec++; if (completed !== 1'b1 || instr.ops.beq !== 1'b1
        || instr.ops.addi !== 1'b0 || instr.pc !== 32'h104) begin nerr++;
      $display("FAIL b2b_second got c=%b beq=%b addi=%b pc=%h want 1/1/0/104",
        completed, instr.ops.beq, instr.ops.addi, instr.pc); end
    enabled = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; enabled = 1'b0; pc = '0; instr_raw = '0;
    tick();
    test_reset();
    test_addi();
    test_add();
    test_beq();
    test_jal_sw_lui();
    test_imm_edges();
    test_illegal();
    test_hold_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use clk (input, 1, rising-edge clock) and rstn (input, 1) as its reset: synchronous, active-low.
REQ-002 The block SHALL have input enabled (1): a valid instruction is present this cycle.
REQ-003 The block SHALL have input pc (32): word address of instr_raw.
REQ-004 The block SHALL have input instr_raw (32): raw RV32I instruction word.
REQ-005 The block SHALL have output completed (1): instr holds a freshly decoded instruction.
REQ-006 The block SHALL have output instr (instructions struct): registered decoded instruction.
REQ-007 The block SHALL have output rs1 (5): combinational instr_raw[19:15], driving the register-file read port.
REQ-008 The block SHALL have output rs2 (5): combinational instr_raw[24:20], driving the register-file read port.
REQ-009 The block SHALL have output may_jump (1): combinational, 1 when instr_raw opcode is JAL (1101111), JALR (1100111) or BRANCH (1100011).

Function
REQ-010 rs1, rs2 and may_jump SHALL depend only on instr_raw, with zero latency, independent of enabled.
REQ-011 At each rising clk edge with rstn=1 and enabled=1, instr SHALL be loaded with the decode of instr_raw, and completed SHALL be set to 1.
REQ-012 At each rising clk edge with rstn=1 and enabled=0, completed SHALL go to 0 and instr SHALL hold its value.
REQ-013 instr.pc SHALL equal pc; instr.rs1/rs2 SHALL equal raw fields [19:15]/[24:20].
REQ-014 instr.rd SHALL equal raw [11:7] for U, J, I-type (incl. JALR, loads) and R-type; it SHALL be 0 for branches, stores and illegal words.
REQ-015 instr.imm SHALL be the 32-bit sign-extended immediate per format: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R = 0. Shift-immediates use shamt [24:20] zero-extended.
REQ-016 The struct SHALL carry a one-hot flag per RV32I base instruction: lui auipc jal jalr beq bne blt bge bltu bgeu lb lh lw lbu lhu sb sh sw addi slti sltiu xori ori andi slli srli srai add sub sll slt sltu xor srl sra or and.
REQ-017 The struct SHALL also carry summary flags: is_conditional_jump (any branch), is_load, is_store, writes_rd, is_illegal.
REQ-018 Flags SHALL be decoded from opcode, funct3, and funct7 bit 30; unrecognised encodings SHALL set is_illegal=1 with all other flags 0 and rd=0.
REQ-019 Immediate values SHALL be byte offsets; any word-address scaling is the execute stage's concern.

Reset
REQ-020 While rstn=0 at a rising edge, completed SHALL become 0 and every instr field SHALL become 0, irrespective of enabled.
REQ-021 Reset SHALL take priority over enabled in the same cycle, and SHALL be usable mid-stream as a pipeline flush.

Structure
REQ-022 The instructions struct typedef and the opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP) SHALL live in the shared package used by the fetch, execute and write stages.
REQ-023 Combinational decode SHALL be one sub-module, decode_comb (instr_raw, pc -> struct); decode_stage registers its output.

Verification
REQ-024 With enabled=1, pc=0x10 and instr_raw=0x00500093, the edge SHALL give addi=1, rd=1, rs1=0, imm=5, pc=0x10, writes_rd=1, completed=1.
REQ-025 With instr_raw=0x002081B3, the outputs SHALL be rs1=1 and rs2=2 at once; after the edge, add=1 and rd=3.
REQ-026 With instr_raw=0x00208463, the outputs SHALL be may_jump=1 at once; after the edge, beq=1, is_conditional_jump=1, imm=8, rd=0.
REQ-027 With instr_raw=0x010000EF (jal=1, rd=1, imm=16, may_jump=1), 0x0020A223 (sw=1, imm=4, rd=0) and 0x123452B7 (lui=1, rd=5, imm=0x12345000), the decode SHALL match the stated values.
REQ-028 For instr_raw=0xFFFFFFFF, the decode SHALL set is_illegal=1 with rd=0.
REQ-029 If enabled is dropped after a decode, completed SHALL go to 0 while instr holds; a subsequent rstn=0 edge SHALL clear instr to all zeros.
